// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory and
// drives the registered pc/instr/valid pair to decode. Optional IF_PERF_CNT_EN adds perf_wait_cnt.
module if_fetch_unit #(
  parameter int                PC_W     = 8,
  parameter int                INSTR_W  = 32,
  parameter int                PC_STEP  = 1,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
`ifdef IF_PERF_CNT_EN
  output logic [15:0]        perf_wait_cnt,
`endif
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    drain_addr_q, drain_addr_d;
  logic [PC_W-1:0]    hold_pc_q, hold_pc_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_out_q, instr_out_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_inc;

  assign pc_inc    = pc_q + PC_W'(PC_STEP);
  assign imem_req  = !rst && (state_q != ST_HOLD);
  assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign pc_out    = pc_out_q;
  assign instr_out = instr_out_q;
  assign valid_out = valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    pc_out_d     = pc_out_q;
    instr_out_d  = instr_out_q;
    valid_d      = valid_q;

    if (branch_taken) begin
      // Redirect wins over everything; any data acked this cycle is dropped.
      valid_d = 1'b0;
      pc_d    = branch_target;
      unique case (state_q)
        ST_REQ: begin
          if (imem_ack) begin
            state_d = ST_REQ;
          end else begin
            drain_addr_d = pc_q;
            state_d      = ST_DRAIN;
          end
        end
        ST_HOLD:  state_d = ST_REQ;
        // A repeat redirect while draining keeps waiting for the old ack,
        // unless that ack lands in this very cycle.
        ST_DRAIN: state_d = imem_ack ? ST_REQ : ST_DRAIN;
        default:  state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (imem_ack) begin
            pc_d = pc_inc;
            if (!stall) begin
              pc_out_d    = pc_q;
              instr_out_d = imem_rdata;
              valid_d     = 1'b1;
            end else begin
              hold_pc_d    = pc_q;
              hold_instr_d = imem_rdata;
              state_d      = ST_HOLD;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            pc_out_d    = hold_pc_q;
            instr_out_d = hold_instr_q;
            valid_d     = 1'b1;
            state_d     = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      pc_out_q     <= '0;
      instr_out_q  <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      pc_out_q     <= pc_out_d;
      instr_out_q  <= instr_out_d;
      valid_q      <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (imem_req && !imem_ack && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_wait_cnt = perf_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a memory model supplies instructions and a
// queue of expected deliveries is checked against pc_out/instr_out after each edge.
module tb_if_fetch_unit;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic               valid_out;
`ifdef IF_PERF_CNT_EN
  logic [15:0]        perf_wait_cnt;
`endif

  if_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .PC_STEP(1), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
`ifdef IF_PERF_CNT_EN
    .perf_wait_cnt(perf_wait_cnt),
`endif
    .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } deliv_t;

  deliv_t             exp_q[$];
  logic [PC_W-1:0]    last_pc;
  logic [INSTR_W-1:0] last_instr;
  int                 tests = 0;
  int                 fails = 0;

  function automatic logic [INSTR_W-1:0] mem(input logic [PC_W-1:0] a);
    return {a, ~a, 8'hC3, a ^ 8'h5A};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check the combinational request, clock, check outputs.
  // deliver >= 0 means the edge should present that pc as a fresh instruction.
  task automatic tick(input string tag, input logic ack, input logic stl,
                      input logic br, input logic [PC_W-1:0] tgt,
                      input logic exp_req, input logic [PC_W-1:0] exp_addr,
                      input int deliver, input logic exp_valid);
    deliv_t d;
    imem_ack      = ack;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    imem_rdata    = ack ? mem(exp_addr) : 32'hDEAD_BEEF;
    #1;
    check({tag, ".req"}, 32'(imem_req), 32'(exp_req));
    if (exp_req) check({tag, ".addr"}, 32'(imem_addr), 32'(exp_addr));
    if (deliver >= 0) exp_q.push_back({PC_W'(deliver), mem(PC_W'(deliver))});
    @(posedge clk);
    #1;
    if (deliver >= 0 && exp_q.size() > 0) begin
      d          = exp_q.pop_front();
      last_pc    = d.pc;
      last_instr = d.instr;
    end
    check({tag, ".valid"}, 32'(valid_out), 32'(exp_valid));
    check({tag, ".pc_out"}, 32'(pc_out), 32'(last_pc));
    check({tag, ".instr_out"}, 32'(instr_out), last_instr);
    $display("[TB] %s ack=%0b stall=%0b br=%0b addr=%h -> valid=%0b pc_out=%h instr=%h",
             tag, ack, stl, br, exp_addr, valid_out, pc_out, instr_out);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_rdata = '0;
    #1;
    check({tag, ".req_in_rst"}, 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    last_pc = '0;
    last_instr = '0;
    check({tag, ".valid"}, 32'(valid_out), 32'd0);
    check({tag, ".pc_out"}, 32'(pc_out), 32'd0);
    check({tag, ".instr_out"}, 32'(instr_out), 32'd0);
`ifdef IF_PERF_CNT_EN
    check({tag, ".perf"}, 32'(perf_wait_cnt), 32'd0);
`endif
    rst = 1'b0;
    $display("[TB] %s reset applied", tag);
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    do_reset("reset");

    // 1: streaming fetch, one instruction per cycle
    tick("seq0", 1, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1);
    tick("seq1", 1, 0, 0, 8'h00, 1, 8'h01, 8'h01, 1);
    tick("seq2", 1, 0, 0, 8'h00, 1, 8'h02, 8'h02, 1);

    // 2: ack under stall goes to the hold buffer and blocks requests
    tick("stall_ack", 1, 1, 0, 8'h00, 1, 8'h03, -1, 1);
    tick("hold1",     0, 1, 0, 8'h00, 0, 8'h00, -1, 1);
    tick("hold2",     0, 1, 0, 8'h00, 0, 8'h00, -1, 1);
    tick("hold3",     0, 1, 0, 8'h00, 0, 8'h00, -1, 1);
    tick("release",   0, 0, 0, 8'h00, 0, 8'h00, 8'h03, 1);
    tick("after_rel", 1, 0, 0, 8'h00, 1, 8'h04, 8'h04, 1);

    // 3: branch coinciding with an ack drops that data
    tick("br_ack",    1, 0, 1, 8'h40, 1, 8'h05, -1, 0);
    tick("tgt40",     1, 0, 0, 8'h00, 1, 8'h40, 8'h40, 1);

    // 4: branch with a request outstanding drains the old address first
    tick("br_drain",  0, 0, 1, 8'h07, 1, 8'h41, -1, 0);
    tick("drain_ack", 1, 0, 0, 8'h00, 1, 8'h41, -1, 0);
    tick("bubble7",   0, 0, 0, 8'h00, 1, 8'h07, -1, 0);
    tick("br_out7",   0, 0, 1, 8'h30, 1, 8'h07, -1, 0);
    tick("drain7a",   0, 0, 1, 8'h40, 1, 8'h07, -1, 0);
    tick("drain7b",   1, 0, 0, 8'h00, 1, 8'h07, -1, 0);
    tick("after_dr",  1, 0, 0, 8'h00, 1, 8'h40, 8'h40, 1);

    // 5: PC wrap at the top of the address space
    tick("br_ff",     1, 0, 1, 8'hFF, 1, 8'h41, -1, 0);
    tick("pc_ff",     1, 0, 0, 8'h00, 1, 8'hFF, 8'hFF, 1);
    tick("pc_wrap",   1, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1);

    // 6: reset while holding discards the buffered instruction
    tick("hold_rst",  1, 1, 0, 8'h00, 1, 8'h01, -1, 1);
    do_reset("rst_hold");
    tick("post_rst",  1, 0, 0, 8'h00, 1, 8'h00, 8'h00, 1);
    tick("wait_stl",  0, 1, 0, 8'h00, 1, 8'h01, -1, 1);
    tick("wait_bub",  0, 0, 0, 8'h00, 1, 8'h01, -1, 0);

`ifdef IF_PERF_CNT_EN
    do_reset("perf_rst");
    tick("perf_w1", 0, 0, 0, 8'h00, 1, 8'h00, -1, 0);
    tick("perf_w2", 0, 0, 0, 8'h00, 1, 8'h00, -1, 0);
    tick("perf_w3", 0, 0, 0, 8'h00, 1, 8'h00, -1, 0);
    check("perf_cnt3", 32'(perf_wait_cnt), 32'd3);
    do_reset("perf_clr");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
